// File: rtl/twophase_pkg.sv
// rtl/twophase_pkg.sv - shared FSM state types and fifo pointer sizing
package twophase_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SETUP = 2'd1,
    TX_WAIT  = 2'd2
  } tx_state_e;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_HOLD = 1'b1
  } rx_state_e;

  // One extra pointer bit separates full from empty when the indices match.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/twophase_bridge_if.sv
// rtl/twophase_bridge_if.sv - clocked stream and 2-phase handshake bundle
interface twophase_bridge_if #(
  parameter int WIDTH = 32
);
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] tx_data;
  logic             req_out;
  logic [WIDTH-1:0] Data_out;
  logic             ack_in;
  logic             req_in;
  logic [WIDTH-1:0] Data_in;
  logic             ack_out;
  logic             rx_valid;
  logic             rx_ready;
  logic [WIDTH-1:0] rx_data;

  // The bridge itself.
  modport slave (
    input  tx_valid, tx_data, ack_in, req_in, Data_in, rx_ready,
    output tx_ready, req_out, Data_out, ack_out, rx_valid, rx_data
  );

  // The producer, consumer and async pipeline around the bridge.
  modport master (
    output tx_valid, tx_data, ack_in, req_in, Data_in, rx_ready,
    input  tx_ready, req_out, Data_out, ack_out, rx_valid, rx_data
  );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous fifo with wrap-bit pointers
module sync_fifo
  import twophase_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A push into a full fifo is legal only when the head leaves on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage is not reset, so the head reads as zero whenever nothing is held.
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; both ends may move on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Data write into the slot addressed by the write index.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/twophase_bridge.sv
// rtl/twophase_bridge.sv - clocked stream to 2-phase bundled-data bridge
module twophase_bridge
  import twophase_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ACK_DLY     = 0
) (
  input logic               clk,
  input logic               rst_n,
  twophase_bridge_if.slave  bus
);
  localparam int CW = (ACK_DLY > 0) ? $clog2(ACK_DLY + 1) : 1;
  // The detect cycle in RX_IDLE already counts as one delay cycle.
  localparam logic [CW-1:0] DLY_LOAD = (ACK_DLY > 1) ? CW'(ACK_DLY - 1) : '0;

  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic [SYNC_STAGES-1:0] req_sync_q;
  logic                   ack_in_sync;
  logic                   req_in_sync;

  tx_state_e        tx_state, tx_state_nxt;
  logic             req_q, req_nxt;
  logic [WIDTH-1:0] dout_q, dout_nxt;
  logic             tx_pop;
  logic             tx_full, tx_empty;
  logic [WIDTH-1:0] tx_head;

  rx_state_e        rx_state, rx_state_nxt;
  logic             ack_q, ack_nxt;
  logic [CW-1:0]    cnt_q, cnt_nxt;
  logic             rx_push;
  logic             rx_full, rx_empty;

  // Handshake inputs are asynchronous; plain flop chains bring them into clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync_q <= '0;
      req_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], bus.ack_in};
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], bus.req_in};
    end
  end

  assign ack_in_sync = ack_sync_q[SYNC_STAGES-1];
  assign req_in_sync = req_sync_q[SYNC_STAGES-1];

  assign bus.tx_ready = !tx_full;
  assign bus.req_out  = req_q;
  assign bus.Data_out = dout_q;
  assign bus.ack_out  = ack_q;
  assign bus.rx_valid = !rx_empty;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (bus.tx_valid && !tx_full),
    .push_data (bus.tx_data),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rx_push),
    .push_data (bus.Data_in),
    .pop       (bus.rx_ready),
    .pop_data  (bus.rx_data),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  // TX next state: the head stays in the fifo until its ack returns, so only
  // one token is ever outstanding and Data_out is frozen while it is.
  always_comb begin
    tx_state_nxt = tx_state;
    req_nxt      = req_q;
    dout_nxt     = dout_q;
    tx_pop       = 1'b0;
    unique case (tx_state)
      TX_IDLE: begin
        if (!tx_empty) begin
          dout_nxt     = tx_head;
          tx_state_nxt = TX_SETUP;
        end
      end
      TX_SETUP: begin
        req_nxt      = !req_q;
        tx_state_nxt = TX_WAIT;
      end
      TX_WAIT: begin
        if (ack_in_sync == req_q) begin
          tx_pop       = 1'b1;
          tx_state_nxt = TX_IDLE;
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  // TX state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      req_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      tx_state <= tx_state_nxt;
      req_q    <= req_nxt;
      dout_q   <= dout_nxt;
    end
  end

  // RX next state: a pending token is acked only once its word is stored, so
  // a full rx fifo holds the ack back instead of losing data.
  always_comb begin
    rx_state_nxt = rx_state;
    ack_nxt      = ack_q;
    cnt_nxt      = cnt_q;
    rx_push      = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (req_in_sync != ack_q) begin
          if (ACK_DLY == 0 && !rx_full) begin
            rx_push = 1'b1;
            ack_nxt = !ack_q;
          end else begin
            cnt_nxt      = DLY_LOAD;
            rx_state_nxt = RX_HOLD;
          end
        end
      end
      RX_HOLD: begin
        if (cnt_q == '0) begin
          if (!rx_full) begin
            rx_push      = 1'b1;
            ack_nxt      = !ack_q;
            rx_state_nxt = RX_IDLE;
          end
        end else begin
          cnt_nxt = cnt_q - CW'(1);
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  // RX state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      ack_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      rx_state <= rx_state_nxt;
      ack_q    <= ack_nxt;
      cnt_q    <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_twophase_bridge.sv
// tb/tb_twophase_bridge.sv - directed vector bench for twophase_bridge
module tb_twophase_bridge;

  typedef struct {
    logic [31:0] data;
    logic        exp_req;
  } tx_vec_t;

  typedef struct {
    logic [31:0] data;
    logic        exp_ack;
  } rx_vec_t;

  logic clk;
  logic rst_n;

  twophase_bridge_if #(.WIDTH(32)) bus0 ();
  twophase_bridge_if #(.WIDTH(32)) bus1 ();

  twophase_bridge #(.WIDTH(32), .DEPTH(4), .SYNC_STAGES(2), .ACK_DLY(0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  twophase_bridge #(.WIDTH(32), .DEPTH(4), .SYNC_STAGES(2), .ACK_DLY(3)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int          n_vec;
  int          n_err;
  logic        auto_ack;
  logic        last_req;
  logic [31:0] tx_seen [$];
  tx_vec_t     tx_tab [3];
  rx_vec_t     rx_tab [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock; sample just after the edge, log each req_out token and
  // optionally answer it at once.
  task automatic step();
    @(posedge clk);
    #1;
    if (bus0.req_out !== last_req) begin
      tx_seen.push_back(bus0.Data_out);
      last_req = bus0.req_out;
    end
    if (auto_ack) bus0.ack_in = bus0.req_out;
  endtask

  task automatic wait_ack0(output int n);
    logic old;
    old = bus0.ack_out;
    n = 0;
    while (bus0.ack_out == old && n < 20) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    logic old;

    tx_tab[0] = '{32'd25, 1'b1};
    tx_tab[1] = '{32'd32, 1'b0};
    tx_tab[2] = '{32'd29, 1'b1};
    rx_tab[0] = '{32'd7, 1'b1};
    rx_tab[1] = '{32'd8, 1'b0};
    rx_tab[2] = '{32'd9, 1'b1};

    n_vec = 0;
    n_err = 0;
    auto_ack = 1'b0;
    last_req = 1'b0;
    rst_n = 1'b1;
    bus0.tx_valid = 1'b0; bus0.tx_data = '0; bus0.ack_in = 1'b0;
    bus0.req_in = 1'b0;   bus0.Data_in = '0; bus0.rx_ready = 1'b0;
    bus1.tx_valid = 1'b0; bus1.tx_data = '0; bus1.ack_in = 1'b0;
    bus1.req_in = 1'b0;   bus1.Data_in = '0; bus1.rx_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    check("rst_tx_ready", 32'(bus0.tx_ready), 32'd1);
    check("rst_rx_valid", 32'(bus0.rx_valid), 32'd0);
    check("rst_rx_data", bus0.rx_data, 32'd0);
    check("rst_req_out", 32'(bus0.req_out), 32'd0);
    check("rst_ack_out", 32'(bus0.ack_out), 32'd0);
    check("rst_data_out", bus0.Data_out, 32'd0);
    #3 rst_n = 1'b1;

    // TX words with an environment that acks each token immediately.
    auto_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("tx_ready_pre", 32'(bus0.tx_ready), 32'd1);
      bus0.tx_valid = 1'b1;
      bus0.tx_data  = tx_tab[i].data;
      step();
      bus0.tx_valid = 1'b0;
      step();
      check("tx_req_setup", 32'(bus0.req_out), 32'(!tx_tab[i].exp_req));
      check("tx_data_setup", bus0.Data_out, tx_tab[i].data);
      step();
      check("tx_req_toggle", 32'(bus0.req_out), 32'(tx_tab[i].exp_req));
      check("tx_data_at_req", bus0.Data_out, tx_tab[i].data);
      repeat (4) begin
        step();
        check("tx_ready_idle", 32'(bus0.tx_ready), 32'd1);
      end
    end

    // RX tokens with a consumer that is always ready.
    bus0.rx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus0.Data_in = rx_tab[i].data;
      bus0.req_in  = !bus0.req_in;
      wait_ack0(n);
      check("rx_ack_latency", 32'(n), 32'd3);
      check("rx_ack_level", 32'(bus0.ack_out), 32'(rx_tab[i].exp_ack));
      check("rx_valid", 32'(bus0.rx_valid), 32'd1);
      check("rx_data", bus0.rx_data, rx_tab[i].data);
      step();
      check("rx_drained", 32'(bus0.rx_valid), 32'd0);
    end

    // RX backpressure: four tokens fill the fifo, the fifth ack waits for a pop.
    bus0.rx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus0.Data_in = 32'(101 + i);
      bus0.req_in  = !bus0.req_in;
      wait_ack0(n);
      check("bp_ack_latency", 32'(n), 32'd3);
    end
    old = bus0.ack_out;
    bus0.Data_in = 32'd105;
    bus0.req_in  = !bus0.req_in;
    repeat (8) step();
    check("bp_ack_stalled", 32'(bus0.ack_out), 32'(old));
    check("bp_head", bus0.rx_data, 32'd101);
    bus0.rx_ready = 1'b1;
    step();
    bus0.rx_ready = 1'b0;
    wait_ack0(n);
    check("bp_ack_after_pop", 32'(n), 32'd1);
    bus0.rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("bp_order", bus0.rx_data, 32'(102 + i));
      step();
    end
    check("bp_empty", 32'(bus0.rx_valid), 32'd0);
    bus0.rx_ready = 1'b0;

    // TX fifo full while the ack is withheld.
    auto_ack = 1'b0;
    tx_seen.delete();
    for (int i = 0; i < 4; i++) begin
      check("full_ready_pre", 32'(bus0.tx_ready), 32'd1);
      bus0.tx_valid = 1'b1;
      bus0.tx_data  = 32'(41 + i);
      step();
    end
    bus0.tx_valid = 1'b0;
    check("full_ready_low", 32'(bus0.tx_ready), 32'd0);
    repeat (5) step();
    check("full_ready_held", 32'(bus0.tx_ready), 32'd0);
    check("full_one_token", 32'(tx_seen.size()), 32'd1);
    bus0.ack_in = bus0.req_out;
    n = 0;
    while (!bus0.tx_ready && n < 20) begin
      step();
      n++;
    end
    check("full_release_latency", 32'(n), 32'd3);
    auto_ack = 1'b1;
    repeat (30) step();
    check("full_tokens", 32'(tx_seen.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check("full_order", (i < tx_seen.size()) ? tx_seen[i] : 32'hdead_beef, 32'(41 + i));
    check("full_idle", 32'(bus0.req_out == bus0.ack_in), 32'd1);

    // Acknowledge delay of three cycles on the second instance.
    bus1.Data_in = 32'd77;
    old = bus1.ack_out;
    bus1.req_in = 1'b1;
    n = 0;
    while (bus1.ack_out == old && n < 20) begin
      step();
      n++;
    end
    check("dly_ack_latency", 32'(n), 32'd6);
    check("dly_rx_data", bus1.rx_data, 32'd77);

    // Reset during TX WAIT, then restart.
    bus0.tx_valid = 1'b1;
    bus0.tx_data  = 32'd50;
    step();
    bus0.tx_valid = 1'b0;
    repeat (10) step();
    auto_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus0.tx_valid = 1'b1;
      bus0.tx_data  = 32'(61 + i);
      step();
    end
    bus0.tx_valid = 1'b0;
    repeat (2) step();
    check("wait_req_high", 32'(bus0.req_out), 32'd1);
    check("wait_ready_low", 32'(bus0.tx_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    bus0.ack_in = 1'b0;
    bus0.req_in = 1'b0;
    bus1.req_in = 1'b0;
    #1;
    check("arst_req_out", 32'(bus0.req_out), 32'd0);
    check("arst_tx_ready", 32'(bus0.tx_ready), 32'd1);
    check("arst_data_out", bus0.Data_out, 32'd0);
    check("arst_rx_valid", 32'(bus0.rx_valid), 32'd0);
    #10;
    rst_n = 1'b1;
    last_req = 1'b0;
    auto_ack = 1'b1;
    bus0.tx_valid = 1'b1;
    bus0.tx_data  = 32'd90;
    step();
    bus0.tx_valid = 1'b0;
    step();
    step();
    check("restart_req", 32'(bus0.req_out), 32'd1);
    check("restart_data", bus0.Data_out, 32'd90);
    repeat (8) step();
    check("restart_ready", 32'(bus0.tx_ready), 32'd1);
    check("restart_idle", 32'(bus0.req_out == bus0.ack_in), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
